// File: rtl/ldpc_ber_axi_up_bridge.sv
// ----------------------------------------------------------------------------
// ldpc_ber_axi_up_bridge
//
// AXI4-Lite slave that turns host register accesses into the single-clock
// up_* request/acknowledge protocol of the LDPC BER tester register map.
// One transaction is in flight at a time. Reads and writes share one state
// machine and are arbitrated round-robin. A transaction that is not
// acknowledged within TIMEOUT_CYCLES returns SLVERR (and 32'hDEAD_DEAD for
// reads) and pulses up_timeout.
//
// Parameters:
//   ADDRESS_WIDTH   word-address width of the up_* side (AXI byte address
//                   is ADDRESS_WIDTH+2 bits)
//   TIMEOUT_CYCLES  acknowledge wait limit in cycles (16-bit), 0 = no limit
//
// Ports:
//   up_clk, up_resetn          clock and asynchronous active-low reset
//   s_axi_aw*, s_axi_w*        AXI write address / data channels (wstrb unused)
//   s_axi_b*                   AXI write response channel
//   s_axi_ar*, s_axi_r*        AXI read address / data channels
//   up_wreq/up_waddr/up_wdata  write request pulse with held address and data
//   up_wack                    write acknowledge from the register map
//   up_rreq/up_raddr           read request pulse with held address
//   up_rdata/up_rack           read data, valid in the acknowledge cycle
//   up_timeout                 one-cycle pulse when a transaction times out
// ----------------------------------------------------------------------------
module ldpc_ber_axi_up_bridge #(
    parameter int unsigned ADDRESS_WIDTH  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                       up_clk,
    input  logic                       up_resetn,

    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [ADDRESS_WIDTH+1:0]   s_axi_awaddr,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    input  logic [31:0]                s_axi_wdata,
    input  logic [3:0]                 s_axi_wstrb,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    output logic [1:0]                 s_axi_bresp,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    input  logic [ADDRESS_WIDTH+1:0]   s_axi_araddr,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [31:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,

    output logic                       up_wreq,
    output logic [ADDRESS_WIDTH-1:0]   up_waddr,
    output logic [31:0]                up_wdata,
    input  logic                       up_wack,
    output logic                       up_rreq,
    output logic [ADDRESS_WIDTH-1:0]   up_raddr,
    input  logic [31:0]                up_rdata,
    input  logic                       up_rack,
    output logic                       up_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        W_REQ,
        W_WAIT,
        B_RESP,
        R_REQ,
        R_WAIT,
        R_RESP
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT  = 16'(TIMEOUT_CYCLES);
    localparam logic        TIMEOUT_ENABLE = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD;
    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [1:0]  RESP_SLVERR    = 2'b10;

    state_t        state;
    logic [15:0]   timeout_cnt;
    logic          last_was_write;
    logic          write_pending;
    logic          read_pending;
    logic          pick_write;
    logic          timeout_hit;
    logic          unused_inputs;

    // A write needs both address and data present; the bridge never accepts
    // one channel without the other.
    assign write_pending = s_axi_awvalid & s_axi_wvalid;
    assign read_pending  = s_axi_arvalid;

    // Round-robin: when both kinds are waiting, the kind not served last
    // wins. last_was_write resets to 0, so the first contest goes to write.
    assign pick_write = write_pending & (~read_pending | ~last_was_write);

    assign timeout_hit = TIMEOUT_ENABLE && (timeout_cnt == TIMEOUT_LIMIT);

    // up_timeout is decoded from the wait state so that it is high in the
    // decision cycle, one cycle ahead of the registered response valid. An
    // acknowledge in that same cycle has priority and suppresses it.
    assign up_timeout = timeout_hit &
                        (((state == W_WAIT) & ~up_wack) |
                         ((state == R_WAIT) & ~up_rack));

    // Byte-lane strobes and the byte offset of the address carry no meaning
    // for a word-only register map.
    assign unused_inputs = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Transaction state machine. All AXI and up_* outputs except up_timeout
    // are registered here. Acknowledges are only looked at in the two wait
    // states, so early, late or cross-direction acknowledges fall through.
    always_ff @(posedge up_clk or negedge up_resetn) begin
        if (!up_resetn) begin
            state          <= IDLE;
            timeout_cnt    <= '0;
            last_was_write <= 1'b0;
            s_axi_awready  <= 1'b0;
            s_axi_wready   <= 1'b0;
            s_axi_bvalid   <= 1'b0;
            s_axi_bresp    <= RESP_OKAY;
            s_axi_arready  <= 1'b0;
            s_axi_rvalid   <= 1'b0;
            s_axi_rdata    <= '0;
            s_axi_rresp    <= RESP_OKAY;
            up_wreq        <= 1'b0;
            up_waddr       <= '0;
            up_wdata       <= '0;
            up_rreq        <= 1'b0;
            up_raddr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_write) begin
                        up_waddr       <= s_axi_awaddr[ADDRESS_WIDTH+1:2];
                        up_wdata       <= s_axi_wdata;
                        s_axi_awready  <= 1'b1;
                        s_axi_wready   <= 1'b1;
                        up_wreq        <= 1'b1;
                        last_was_write <= 1'b1;
                        state          <= W_REQ;
                    end else if (read_pending) begin
                        up_raddr       <= s_axi_araddr[ADDRESS_WIDTH+1:2];
                        s_axi_arready  <= 1'b1;
                        up_rreq        <= 1'b1;
                        last_was_write <= 1'b0;
                        state          <= R_REQ;
                    end
                end

                // The AXI address/data handshake completes in this cycle,
                // concurrently with the up_wreq pulse.
                W_REQ: begin
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    up_wreq       <= 1'b0;
                    timeout_cnt   <= '0;
                    state         <= W_WAIT;
                end

                W_WAIT: begin
                    if (up_wack) begin
                        s_axi_bresp  <= RESP_OKAY;
                        s_axi_bvalid <= 1'b1;
                        state        <= B_RESP;
                    end else if (timeout_hit) begin
                        s_axi_bresp  <= RESP_SLVERR;
                        s_axi_bvalid <= 1'b1;
                        state        <= B_RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end

                B_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end

                R_REQ: begin
                    s_axi_arready <= 1'b0;
                    up_rreq       <= 1'b0;
                    timeout_cnt   <= '0;
                    state         <= R_WAIT;
                end

                R_WAIT: begin
                    if (up_rack) begin
                        s_axi_rdata  <= up_rdata;
                        s_axi_rresp  <= RESP_OKAY;
                        s_axi_rvalid <= 1'b1;
                        state        <= R_RESP;
                    end else if (timeout_hit) begin
                        s_axi_rdata  <= TIMEOUT_RDATA;
                        s_axi_rresp  <= RESP_SLVERR;
                        s_axi_rvalid <= 1'b1;
                        state        <= R_RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end

                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_ber_axi_up_bridge.sv
// ----------------------------------------------------------------------------
// tb_ldpc_ber_axi_up_bridge
//
// Self-checking bench for ldpc_ber_axi_up_bridge with TIMEOUT_CYCLES = 8.
// A table of single transactions (address, data, acknowledge timing,
// expected capture, response, latency and timeout count) is applied in a
// loop; arbitration order, a late acknowledge after a timeout and a reset in
// the middle of a write are exercised as hand-written sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_ldpc_ber_axi_up_bridge;

    localparam int TIMEOUT = 8;

    logic        up_clk;
    logic        up_resetn;
    logic        s_axi_awvalid, s_axi_awready;
    logic [11:0] s_axi_awaddr;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [11:0] s_axi_araddr;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        up_wreq;
    logic [9:0]  up_waddr;
    logic [31:0] up_wdata;
    logic        up_wack;
    logic        up_rreq;
    logic [9:0]  up_raddr;
    logic [31:0] up_rdata;
    logic        up_rack;
    logic        up_timeout;

    ldpc_ber_axi_up_bridge #(
        .ADDRESS_WIDTH  (10),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .up_clk        (up_clk),
        .up_resetn     (up_resetn),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .up_wreq       (up_wreq),
        .up_waddr      (up_waddr),
        .up_wdata      (up_wdata),
        .up_wack       (up_wack),
        .up_rreq       (up_rreq),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_rack       (up_rack),
        .up_timeout    (up_timeout)
    );

    // One transaction: ack_at is the acknowledge cycle relative to the
    // request cycle (-1 = never), noise drives the opposite-direction
    // acknowledge high throughout, ready_delay is the number of cycles the
    // response valid is left waiting. exp_latency counts from the cycle the
    // AXI valids are first driven to the first cycle the response valid is up.
    typedef struct packed {
        bit          is_write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_value;
        int          ack_at;
        bit          noise;
        int          ready_delay;
        logic [9:0]  exp_addr;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_latency;
        int          exp_timeouts;
    } vec_t;

    localparam int NUM_VECS = 9;
    vec_t vecs [0:NUM_VECS-1];

    int tests_run;
    int tests_failed;

    int          res_req_cnt;
    logic [9:0]  res_addr;
    logic [31:0] res_wdata;
    logic [1:0]  res_resp;
    logic [31:0] res_rdata;
    int          res_latency;
    int          res_timeouts;
    int          res_unstable;
    bit          res_done;

    initial begin
        up_clk = 1'b0;
        forever #5 up_clk = ~up_clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit hit, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t makeVec(input bit is_write, input logic [11:0] addr,
                                     input logic [31:0] wdata, input logic [31:0] rd_value,
                                     input int ack_at, input bit noise, input int ready_delay,
                                     input logic [9:0] exp_addr, input logic [1:0] exp_resp,
                                     input logic [31:0] exp_rdata, input int exp_latency,
                                     input int exp_timeouts);
        vec_t v;
        v.is_write     = is_write;
        v.addr         = addr;
        v.wdata        = wdata;
        v.rd_value     = rd_value;
        v.ack_at       = ack_at;
        v.noise        = noise;
        v.ready_delay  = ready_delay;
        v.exp_addr     = exp_addr;
        v.exp_resp     = exp_resp;
        v.exp_rdata    = exp_rdata;
        v.exp_latency  = exp_latency;
        v.exp_timeouts = exp_timeouts;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_rready  = 1'b0;
        up_wack       = 1'b0;
        up_rack       = 1'b0;
        up_rdata      = 32'h0BAD_0BAD;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                                          s_axi_arready, s_axi_rvalid, s_axi_rresp,
                                          up_wreq, up_rreq, up_timeout}), 32'h0);
        checkOutput({tag, "_rdata"}, s_axi_rdata, 32'h0);
        checkOutput({tag, "_wdata"}, up_wdata, 32'h0);
        checkOutput({tag, "_addr"}, 32'({up_waddr, up_raddr}), 32'h0);
    endtask

    // Drives one transaction to completion, acting as AXI master and as the
    // register-map responder, and records what the bridge did.
    task automatic applyStimulus(input vec_t v);
        int req_cycle;
        int valid_cycle;
        bit hs;
        bit vld;
        bit rdy;
        req_cycle    = -1;
        valid_cycle  = -1;
        hs           = 1'b0;
        res_req_cnt  = 0;
        res_addr     = '0;
        res_wdata    = '0;
        res_resp     = '0;
        res_rdata    = '0;
        res_timeouts = 0;
        res_unstable = 0;
        res_done     = 1'b0;
        for (int k = 0; k < 40 && !res_done; k++) begin
            @(negedge up_clk);
            if (v.is_write) begin
                s_axi_awvalid = !hs;
                s_axi_wvalid  = !hs;
                s_axi_awaddr  = v.addr;
                s_axi_wdata   = v.wdata;
            end else begin
                s_axi_arvalid = !hs;
                s_axi_araddr  = v.addr;
            end
            up_wack  = 1'b0;
            up_rack  = 1'b0;
            up_rdata = 32'h0BAD_0BAD;
            if (req_cycle >= 0 && v.ack_at > 0 && k == req_cycle + v.ack_at) begin
                if (v.is_write) begin
                    up_wack = 1'b1;
                end else begin
                    up_rack  = 1'b1;
                    up_rdata = v.rd_value;
                end
            end
            if (v.noise) begin
                if (v.is_write) up_rack = 1'b1;
                else            up_wack = 1'b1;
            end
            rdy = (valid_cycle >= 0) && (k >= valid_cycle + v.ready_delay);
            s_axi_bready = v.is_write && rdy;
            s_axi_rready = !v.is_write && rdy;
            #1;
            if (v.is_write ? up_rreq : up_wreq) res_req_cnt += 100;
            if (v.is_write ? up_wreq : up_rreq) begin
                res_req_cnt++;
                req_cycle = k;
                res_addr  = v.is_write ? up_waddr : up_raddr;
                res_wdata = up_wdata;
                if (v.ack_at == 0) begin
                    if (v.is_write) begin
                        up_wack = 1'b1;
                    end else begin
                        up_rack  = 1'b1;
                        up_rdata = v.rd_value;
                    end
                end
            end
            if (v.is_write ? (s_axi_awready && s_axi_wready) : s_axi_arready) hs = 1'b1;
            if (up_timeout) res_timeouts++;
            vld = v.is_write ? s_axi_bvalid : s_axi_rvalid;
            if (vld) begin
                if (valid_cycle < 0) begin
                    valid_cycle = k;
                    res_resp    = v.is_write ? s_axi_bresp : s_axi_rresp;
                    res_rdata   = s_axi_rdata;
                end else if ((v.is_write ? s_axi_bresp : s_axi_rresp) !== res_resp ||
                             (!v.is_write && s_axi_rdata !== res_rdata)) begin
                    res_unstable++;
                end
                if (rdy) res_done = 1'b1;
            end else if (valid_cycle >= 0) begin
                res_unstable++;
            end
        end
        @(negedge up_clk);
        clearInputs();
        res_latency = valid_cycle;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput({tag, "_done"}, 32'(res_done), 32'd1);
        checkOutput({tag, "_req_count"}, 32'(res_req_cnt), 32'd1);
        checkOutput({tag, "_addr"}, 32'(res_addr), 32'(v.exp_addr));
        if (v.is_write) checkOutput({tag, "_wdata"}, res_wdata, v.wdata);
        else            checkOutput({tag, "_rdata"}, res_rdata, v.exp_rdata);
        checkOutput({tag, "_resp"}, 32'(res_resp), 32'(v.exp_resp));
        checkOutput({tag, "_latency"}, 32'(res_latency), 32'(v.exp_latency));
        checkOutput({tag, "_timeouts"}, 32'(res_timeouts), 32'(v.exp_timeouts));
        checkOutput({tag, "_unstable"}, 32'(res_unstable), 32'd0);
    endtask

    // Keeps write and read valids up together until two of each are issued
    // and records the order of request pulses (1 = write) in a shift register.
    task automatic runArbitration();
        int w_issued;
        int r_issued;
        int n;
        int overlap;
        int b_cnt;
        int r_cnt;
        int drain;
        logic [3:0] order;
        bit w_ack_next;
        bit r_ack_next;
        w_issued = 0; r_issued = 0; n = 0; overlap = 0;
        b_cnt = 0; r_cnt = 0; drain = 0; order = 4'b0000;
        w_ack_next = 1'b0; r_ack_next = 1'b0;
        for (int k = 0; k < 80 && drain < 6; k++) begin
            @(negedge up_clk);
            s_axi_awvalid = (w_issued < 2);
            s_axi_wvalid  = (w_issued < 2);
            s_axi_awaddr  = (w_issued == 0) ? 12'h100 : 12'h104;
            s_axi_wdata   = 32'h1000_0000 + 32'(w_issued);
            s_axi_arvalid = (r_issued < 2);
            s_axi_araddr  = (r_issued == 0) ? 12'h200 : 12'h204;
            s_axi_bready  = 1'b1;
            s_axi_rready  = 1'b1;
            up_wack       = w_ack_next;
            up_rack       = r_ack_next;
            up_rdata      = 32'h7777_0000;
            #1;
            w_ack_next = up_wreq;
            r_ack_next = up_rreq;
            if (up_wreq && up_rreq) overlap++;
            if (up_wreq) begin order = {order[2:0], 1'b1}; n++; end
            if (up_rreq) begin order = {order[2:0], 1'b0}; n++; end
            if (s_axi_awvalid && s_axi_awready && s_axi_wready) w_issued++;
            if (s_axi_arvalid && s_axi_arready) r_issued++;
            if (s_axi_bvalid) b_cnt++;
            if (s_axi_rvalid) r_cnt++;
            if (n >= 4) drain++;
        end
        @(negedge up_clk);
        clearInputs();
        checkOutput("arb_order", 32'(order), 32'h0000_000A);
        checkOutput("arb_req_count", 32'(n), 32'd4);
        checkOutput("arb_overlap", 32'(overlap), 32'd0);
        checkOutput("arb_bvalid_count", 32'(b_cnt), 32'd2);
        checkOutput("arb_rvalid_count", 32'(r_cnt), 32'd2);
    endtask

    initial begin
        int late_bad;
        int post_bad;

        tests_run    = 0;
        tests_failed = 0;

        //                  wr    addr     wdata          rd_value       ack nz rdy exp_addr resp   exp_rdata      lat to
        vecs[0] = makeVec(1'b1, 12'h008, 32'h1234_5678, 32'h0,          1, 0, 1, 10'h002, 2'b00, 32'h0,          3, 0);
        vecs[1] = makeVec(1'b0, 12'h00C, 32'h0,         32'h4350_444C,  1, 0, 5, 10'h003, 2'b00, 32'h4350_444C, 3, 0);
        vecs[2] = makeVec(1'b1, 12'hFFC, 32'hA5A5_5A5A, 32'h0,          4, 0, 2, 10'h3FF, 2'b00, 32'h0,          6, 0);
        vecs[3] = makeVec(1'b0, 12'h000, 32'h0,         32'hFFFF_FFFF,  3, 1, 1, 10'h000, 2'b00, 32'hFFFF_FFFF, 5, 0);
        vecs[4] = makeVec(1'b1, 12'h010, 32'h0,         32'h0,         -1, 1, 1, 10'h004, 2'b10, 32'h0,         11, 1);
        vecs[5] = makeVec(1'b0, 12'h020, 32'h0,         32'h2222_3333,  0, 0, 1, 10'h008, 2'b10, 32'hDEAD_DEAD, 11, 1);
        vecs[6] = makeVec(1'b1, 12'h044, 32'h0F0F_0F0F, 32'h0,          9, 0, 1, 10'h011, 2'b00, 32'h0,         11, 0);
        vecs[7] = makeVec(1'b0, 12'h3F8, 32'h0,         32'h1357_9BDF, 10, 0, 3, 10'h0FE, 2'b10, 32'hDEAD_DEAD, 11, 1);
        vecs[8] = makeVec(1'b0, 12'h104, 32'h0,         32'h89AB_CDEF,  2, 0, 1, 10'h041, 2'b00, 32'h89AB_CDEF, 4, 0);

        s_axi_awaddr = '0;
        s_axi_wdata  = '0;
        s_axi_wstrb  = 4'hF;
        s_axi_araddr = '0;
        clearInputs();
        up_resetn = 1'b1;
        #2 up_resetn = 1'b0;

        @(negedge up_clk);
        #1;
        checkAllZero("reset");
        @(negedge up_clk);
        up_resetn = 1'b1;

        runArbitration();

        for (int i = 0; i < NUM_VECS; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Read that times out, then a stray acknowledge three cycles after
        // the timeout pulse, while the bridge is back in IDLE.
        runVector(makeVec(1'b0, 12'h030, 32'h0, 32'h0, -1, 0, 1, 10'h00C, 2'b10,
                          32'hDEAD_DEAD, 11, 1), "late");
        up_rack  = 1'b1;
        up_rdata = 32'h5555_AAAA;
        late_bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(negedge up_clk);
                up_rack = 1'b0;
            end
            #1;
            if (s_axi_rvalid || up_rreq || up_timeout) late_bad++;
        end
        checkOutput("late_rack_activity", 32'(late_bad), 32'd0);
        checkOutput("late_rack_rdata", s_axi_rdata, 32'hDEAD_DEAD);

        // Reset asserted asynchronously while a write waits for its ack.
        @(negedge up_clk);
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_awaddr  = 12'h008;
        s_axi_wdata   = 32'hCAFE_F00D;
        @(negedge up_clk);
        #1;
        checkOutput("rst_wreq", 32'(up_wreq), 32'd1);
        @(negedge up_clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        #1;
        checkOutput("rst_waddr_before", 32'(up_waddr), 32'd2);
        #2 up_resetn = 1'b0;
        #1;
        checkAllZero("rst_mid");
        @(negedge up_clk);
        up_resetn = 1'b1;
        post_bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge up_clk);
            #1;
            if (s_axi_bvalid || up_wreq || s_axi_awready) post_bad++;
        end
        checkOutput("rst_no_bvalid", 32'(post_bad), 32'd0);
        runVector(makeVec(1'b0, 12'h01C, 32'h0, 32'h0A0B_0C0D, 1, 0, 1, 10'h007, 2'b00,
                          32'h0A0B_0C0D, 3, 0), "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
